// File: rtl/d3s_seq_pkg.sv
// Shared types for the WR RF-counter sync sequencer: state encoding, error codes,
// cycle-value type and the timeout counter width.
package d3s_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TIME = 3'd1,
    ST_ARM_RF    = 3'd2,
    ST_WAIT_RF   = 3'd3,
    ST_ARM_TRIG  = 3'd4,
    ST_WAIT_TRIG = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } seq_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE       = 2'd0;
  localparam err_code_t ERR_LINK       = 2'd1;
  localparam err_code_t ERR_RF_TMO     = 2'd2;
  localparam err_code_t ERR_TRIG_ABORT = 2'd3;

  typedef logic [27:0] sync_cycles_t;

  localparam int unsigned TMO_W = 32;

  function automatic logic is_busy(input seq_state_t s);
    return s inside {ST_WAIT_TIME, ST_ARM_RF, ST_WAIT_RF, ST_ARM_TRIG, ST_WAIT_TRIG};
  endfunction

endpackage

// File: rtl/d3s_timeout_cnt.sv
// Saturating 32-bit timeout down-counter with synchronous load and count enable.
module d3s_timeout_cnt
  import d3s_seq_pkg::*;
(
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMO_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TMO_W'(1);
    end
  end

  // Also flags the tick that takes the count from 1 to 0, so expiry lands on that edge.
  assign zero = (cnt == '0) || (en && (cnt == TMO_W'(1)));

endmodule

// File: rtl/d3s_sync_seq.sv
// Sequences one RF-counter sync: wait for WR time, arm RF sync, arm trigger, latch snapshot.
//   IDLE  0 idle          | WAIT_TIME 1 wait link+time | ARM_RF 2 pulse rf_arm | WAIT_RF 3 wait rf_done
//   ARM_TRIG 4 pulse arm  | WAIT_TRIG 5 wait trigger   | DONE 6 success        | ERROR 7 err_o valid
module d3s_sync_seq
  import d3s_seq_pkg::*;
#(
  parameter int unsigned g_rf_timeout   = 2000000,
  parameter int unsigned g_trig_timeout = 0
) (
  input  logic         clk_sys_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [27:0]  sync_cycles_i,
  input  logic         tm_link_up_i,
  input  logic         tm_time_valid_i,
  output logic         rf_arm_o,
  output logic [27:0]  rf_arm_cycles_o,
  input  logic         rf_done_i,
  output logic         trig_arm_o,
  input  logic         trig_done_i,
  input  logic [31:0]  trig_snapshot_i,
  output logic [31:0]  snapshot_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         irq_o,
  output logic [1:0]   err_o,
  output logic [2:0]   state_o
);

  localparam logic [TMO_W-1:0] RF_TMO      = TMO_W'(g_rf_timeout);
  localparam logic [TMO_W-1:0] TRIG_TMO    = TMO_W'(g_trig_timeout);
  localparam logic             TRIG_TMO_EN = (g_trig_timeout != 0);

  seq_state_t       state, state_next;
  sync_cycles_t     cycles_q;
  err_code_t        err_code;
  logic             link_ok;
  logic             take_start, arm_rf, arm_trig, take_snap, err_set;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [TMO_W-1:0] cnt_val;

  assign link_ok = tm_link_up_i && tm_time_valid_i;

  d3s_timeout_cnt u_tmo (
    .clk_sys  (clk_sys_i),
    .rst_n    (rst_n_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next = state;
    take_start = 1'b0;
    arm_rf     = 1'b0;
    arm_trig   = 1'b0;
    take_snap  = 1'b0;
    err_set    = 1'b0;
    err_code   = ERR_NONE;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_en     = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          take_start = 1'b1;
          state_next = ST_WAIT_TIME;
        end
      end
      ST_WAIT_TIME: begin
        if (link_ok) state_next = ST_ARM_RF;
      end
      ST_ARM_RF: begin
        cnt_load   = 1'b1;
        cnt_val    = RF_TMO;
        arm_rf     = 1'b1;
        state_next = ST_WAIT_RF;
      end
      ST_WAIT_RF: begin
        cnt_en = 1'b1;
        if (rf_done_i) begin
          state_next = ST_ARM_TRIG;
        end else if (cnt_zero) begin
          err_set  = 1'b1;
          err_code = ERR_RF_TMO;
        end
      end
      ST_ARM_TRIG: begin
        cnt_load   = 1'b1;
        cnt_val    = TRIG_TMO;
        arm_trig   = 1'b1;
        state_next = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        cnt_en = 1'b1;
        if (trig_done_i) begin
          take_snap  = 1'b1;
          state_next = ST_DONE;
        end else if (TRIG_TMO_EN && cnt_zero) begin
          err_set  = 1'b1;
          err_code = ERR_TRIG_ABORT;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Overrides applied lowest priority first, so abort ends up on top.
    if (!link_ok && (state inside {ST_ARM_RF, ST_WAIT_RF, ST_ARM_TRIG, ST_WAIT_TRIG})) begin
      err_set   = 1'b1;
      err_code  = ERR_LINK;
      take_snap = 1'b0;
      arm_rf    = 1'b0;
      arm_trig  = 1'b0;
    end
    if (abort_i && (state != ST_IDLE)) begin
      err_set    = 1'b1;
      err_code   = ERR_TRIG_ABORT;
      take_start = 1'b0;
      take_snap  = 1'b0;
      arm_rf     = 1'b0;
      arm_trig   = 1'b0;
    end
    if (err_set) state_next = ST_ERROR;
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      cycles_q        <= '0;
      rf_arm_o        <= 1'b0;
      rf_arm_cycles_o <= '0;
      trig_arm_o      <= 1'b0;
      snapshot_o      <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      irq_o           <= 1'b0;
      err_o           <= ERR_NONE;
    end else begin
      state      <= state_next;
      rf_arm_o   <= arm_rf;
      trig_arm_o <= arm_trig;
      busy_o     <= is_busy(state_next);
      irq_o      <= (state_next != state) && (state_next inside {ST_DONE, ST_ERROR});
      if (take_start) cycles_q <= sync_cycles_i;
      if (arm_rf) rf_arm_cycles_o <= cycles_q;
      if (take_snap) snapshot_o <= trig_snapshot_i;
      if (take_start) begin
        done_o <= 1'b0;
        err_o  <= ERR_NONE;
      end else if (err_set) begin
        done_o <= 1'b0;
        err_o  <= err_code;
      end else if (take_snap) begin
        done_o <= 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_d3s_sync_seq.sv
// Bench for d3s_sync_seq: directed and randomized sequences checked against a timeline model.
module tb_d3s_sync_seq;

  localparam int RF_TMO   = 100;
  localparam int TRIG_TMO = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [27:0] sync_cycles = '0;
  logic        link_up = 1'b0;
  logic        time_valid = 1'b0;
  logic        rf_done = 1'b0;
  logic        trig_done = 1'b0;
  logic [31:0] trig_snapshot = '0;

  logic        rf_arm_o, trig_arm_o, busy_o, done_o, irq_o;
  logic [27:0] rf_arm_cycles_o;
  logic [31:0] snapshot_o;
  logic [1:0]  err_o;
  logic [2:0]  state_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // event log filled by the monitor, only read by the stimulus process
  int          n_rf = 0, t_rf = 0, n_trig = 0, t_trig = 0, n_irq = 0, t_irq = 0, n_both = 0;
  logic [27:0] v_rf = '0;
  logic [31:0] exp_snap = '0;

  d3s_sync_seq #(
    .g_rf_timeout   (RF_TMO),
    .g_trig_timeout (TRIG_TMO)
  ) dut (
    .clk_sys_i       (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .abort_i         (abort),
    .sync_cycles_i   (sync_cycles),
    .tm_link_up_i    (link_up),
    .tm_time_valid_i (time_valid),
    .rf_arm_o        (rf_arm_o),
    .rf_arm_cycles_o (rf_arm_cycles_o),
    .rf_done_i       (rf_done),
    .trig_arm_o      (trig_arm_o),
    .trig_done_i     (trig_done),
    .trig_snapshot_i (trig_snapshot),
    .snapshot_o      (snapshot_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .irq_o           (irq_o),
    .err_o           (err_o),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rf_arm_o) begin
      n_rf <= n_rf + 1;
      t_rf <= cyc;
      v_rf <= rf_arm_cycles_o;
    end
    if (trig_arm_o) begin
      n_trig <= n_trig + 1;
      t_trig <= cyc;
    end
    if (irq_o) begin
      n_irq <= n_irq + 1;
      t_irq <= cyc;
    end
    if (rf_arm_o && trig_arm_o) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sequence. Edge numbers: inputs set now are consumed by edge cyc+1.
  // wt: edges of time_valid low after WAIT_TIME entry; d: rf_done edge offset from the arm edge;
  // e: trig_done offset from the trigger-arm edge; kind: 0 none, 1 abort, 2 link drop, 3 link drop at the natural end.
  task automatic run_txn(input int wt, input int d, input int e, input int kind, input int fo,
                         input logic stale, input logic busy_start,
                         input logic [27:0] sync, input logic [31:0] snap);
    int s, lok, a, t, endn, endf, x, bs, stop;
    int b_rf, b_trig, b_irq, exp_err;
    logic exp_rf, exp_trig, exp_done;

    b_rf = n_rf; b_trig = n_trig; b_irq = n_irq;
    s   = cyc + 1;
    lok = s + 1 + wt;
    a   = lok + 1;
    t   = a + d + 1;
    if (d > RF_TMO) begin
      endn = a + RF_TMO;    exp_err = 2;
    end else if (e > TRIG_TMO) begin
      endn = t + TRIG_TMO;  exp_err = 3;
    end else begin
      endn = t + e;         exp_err = 0;
    end
    case (kind)
      1: x = s + 1 + (fo % (endn - s));
      2: x = a + (fo % (endn - a + 1));
      3: x = endn;
      default: x = endn + 1000;
    endcase
    endf = (kind != 0) ? x : endn;
    if (kind == 1) exp_err = 3;
    if (kind >= 2) exp_err = 1;
    exp_rf   = (a < endf);
    exp_trig = (d <= RF_TMO) && (t < endf);
    exp_done = (kind == 0) && (exp_err == 0);
    if (exp_done) exp_snap = snap;
    bs   = s + 1 + (fo % (endf - s));
    stop = endf + 2;

    for (int q = s; q <= stop; q++) begin
      start         = (q == s) || (busy_start && q == bs);
      sync_cycles   = (q == s) ? sync : 28'($urandom);
      abort         = (kind == 1) && (q == x);
      time_valid    = (q >= lok);
      link_up       = !((kind >= 2) && q >= x && q <= endf + 1);
      rf_done       = (q == a + d) || (stale && q == a);
      trig_done     = (q == t + e) || (stale && q == t);
      trig_snapshot = (q == t + e) ? snap : $urandom;
      tick();
    end
    start = 1'b0; abort = 1'b0; rf_done = 1'b0; trig_done = 1'b0;
    link_up = 1'b1; time_valid = 1'b1;
    tick();

    check("rf_arm_count", n_rf - b_rf, {63'd0, exp_rf});
    if (exp_rf) begin
      check("rf_arm_time", t_rf, a);
      check("rf_arm_cycles", v_rf, sync);
    end
    check("trig_arm_count", n_trig - b_trig, {63'd0, exp_trig});
    if (exp_trig) check("trig_arm_time", t_trig, t);
    check("irq_count", n_irq - b_irq, 1);
    check("irq_time", t_irq, endf);
    check("err", err_o, exp_err);
    check("done", done_o, {63'd0, exp_done});
    check("snapshot", snapshot_o, exp_snap);
    check("busy_idle", busy_o, 0);
    check("final_state", state_o, exp_done ? 6 : 7);
  endtask

  // Reset pulled while waiting for the trigger; the late trigger must leave no trace.
  task automatic reset_in_wait_trig();
    int s, t, b_irq, b_trig;
    s = cyc + 1;
    t = s + 2 + 3 + 1;
    for (int q = s; q <= t + 2; q++) begin
      start   = (q == s);
      rf_done = (q == s + 5);
      tick();
    end
    start = 1'b0; rf_done = 1'b0;
    check("pre_reset_busy", busy_o, 1);
    check("pre_reset_state", state_o, 5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_state", state_o, 0);
    check("rst_snapshot", snapshot_o, 0);
    check("rst_outputs", {done_o, irq_o, err_o, rf_arm_o, trig_arm_o}, 0);
    check("rst_arm_cycles", rf_arm_cycles_o, 0);
    exp_snap = '0;
    b_irq = n_irq; b_trig = n_trig;
    trig_done = 1'b1;
    trig_snapshot = $urandom;
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();
    tick();
    trig_done = 1'b0;
    repeat (10) tick();
    check("post_reset_irq", n_irq - b_irq, 0);
    check("post_reset_trig_arm", n_trig - b_trig, 0);
    check("post_reset_state", state_o, 0);
    check("post_reset_snapshot", snapshot_o, 0);
  endtask

  initial begin
    int wt, d, e, kind;
    repeat (3) tick();
    check("reset_state", state_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_flags", {done_o, irq_o, err_o, rf_arm_o, trig_arm_o}, 0);
    check("reset_snapshot", snapshot_o, 0);
    rst_n = 1'b1;
    link_up = 1'b1;
    time_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("abort_in_idle_state", state_o, 0);
    check("abort_in_idle_irq", n_irq, 0);

    run_txn(0, 10, 5, 0, 0, 1'b0, 1'b0, 28'd123, 32'd1000);
    run_txn(500, 10, 5, 0, 0, 1'b0, 1'b0, 28'($urandom), $urandom);
    run_txn(0, 200, 5, 0, 0, 1'b0, 1'b0, 28'($urandom), $urandom);
    run_txn(1, RF_TMO, 3, 0, 0, 1'b0, 1'b0, 28'($urandom), $urandom);
    run_txn(1, RF_TMO + 1, 3, 0, 0, 1'b0, 1'b0, 28'($urandom), $urandom);
    run_txn(0, 4, TRIG_TMO, 0, 0, 1'b0, 1'b0, 28'($urandom), $urandom);
    run_txn(0, 4, TRIG_TMO + 1, 0, 0, 1'b0, 1'b0, 28'($urandom), $urandom);
    run_txn(2, 6, 4, 0, 0, 1'b1, 1'b1, 28'($urandom), $urandom);
    run_txn(0, 5, 7, 3, 0, 1'b0, 1'b0, 28'($urandom), $urandom);
    run_txn(0, 10, 5, 1, 4, 1'b0, 1'b0, 28'($urandom), $urandom);
    run_txn(0, 8, 9, 0, 0, 1'b0, 1'b0, 28'($urandom), $urandom);
    reset_in_wait_trig();

    for (int i = 0; i < 30; i++) begin
      wt = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(RF_TMO - 1, RF_TMO + 1);
        1:       d = 150;
        default: d = $urandom_range(1, 20);
      endcase
      case ($urandom_range(0, 3))
        0:       e = $urandom_range(TRIG_TMO - 1, TRIG_TMO + 1);
        1:       e = 80;
        default: e = $urandom_range(1, 10);
      endcase
      kind = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run_txn(wt, d, e, kind, $urandom_range(0, 100000), 1'($urandom), 1'($urandom),
              28'($urandom), $urandom);
    end

    check("never_both_arms", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
